// File: rtl/tx_header_ser.sv
// Transmit framer: serializes a 112-bit Ethernet header MSB-byte-first, passes the
// payload through unchanged and zero-pads short payloads up to the minimum length.

package defines;
    typedef logic [111:0] header;
endpackage

module tx_header_ser #(
    parameter int         HDR_BYTES   = 14,
    parameter int         MIN_PAYLOAD = 46,
    parameter logic [7:0] PAD_BYTE    = 8'h00
) (
    input  logic          clk,
    input  logic          rst_n,
    input  defines::header tx_header,
    input  logic          hdr_valid,
    output logic          hdr_ready,
    input  logic [7:0]    s_tdata,
    input  logic          s_tvalid,
    input  logic          s_tlast,
    output logic          s_tready,
    output logic [7:0]    m_tdata,
    output logic          m_tvalid,
    output logic          m_tlast,
    input  logic          m_tready,
    output logic          busy,
    output logic          frame_done
);

    localparam int PW = $clog2(MIN_PAYLOAD + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_HDR     = 2'd1;
    localparam logic [1:0] S_PAYLOAD = 2'd2;
    localparam logic [1:0] S_PAD     = 2'd3;

    localparam logic [3:0]    H_LAST = 4'(HDR_BYTES - 1);
    localparam logic [PW-1:0] P_MAX  = PW'(MIN_PAYLOAD);
    localparam logic [PW-1:0] P_LAST = PW'(MIN_PAYLOAD - 1);

    logic [1:0]     state_q, state_d;
    defines::header sr_q, sr_d;
    logic [3:0]     hcnt_q, hcnt_d;
    logic [PW-1:0]  pcnt_q, pcnt_d;
    logic           frame_done_q, frame_done_d;

    logic           m_hs;
    logic [PW-1:0]  pcnt_inc;

    // Handshake outputs are gated by rst_n so they read 0 for the whole reset
    // cycle, not just after the reset edge has cleared the state register.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        hdr_ready = 1'b0;
        s_tready  = 1'b0;
        m_tvalid  = 1'b0;
        m_tdata   = 8'h00;
        m_tlast   = 1'b0;
        if (rst_n) begin
            case (state_q)
                S_IDLE: hdr_ready = 1'b1;
                S_HDR: begin
                    m_tvalid = 1'b1;
                    m_tdata  = sr_q[111:104];
                end
                S_PAYLOAD: begin
                    m_tdata  = s_tdata;
                    m_tvalid = s_tvalid;
                    s_tready = m_tready;
                    m_tlast  = s_tlast && (pcnt_q >= P_LAST);
                end
                S_PAD: begin
                    m_tvalid = 1'b1;
                    m_tdata  = PAD_BYTE;
                    m_tlast  = (pcnt_q == P_LAST);
                end
                default: ;
            endcase
        end
    end

    assign m_hs     = m_tvalid && m_tready;
    assign pcnt_inc = (pcnt_q == P_MAX) ? pcnt_q : pcnt_q + PW'(1);

    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        hcnt_d       = hcnt_q;
        pcnt_d       = pcnt_q;
        frame_done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (hdr_valid) begin
                    sr_d    = tx_header;
                    hcnt_d  = 4'd0;
                    pcnt_d  = '0;
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                if (m_hs) begin
                    sr_d   = {sr_q[103:0], 8'h00};
                    hcnt_d = hcnt_q + 4'd1;
                    if (hcnt_q == H_LAST) state_d = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (m_hs) begin
                    pcnt_d = pcnt_inc;
                    if (s_tlast) begin
                        // pcnt_q >= MIN_PAYLOAD-1 is the same test as pcnt+1 >= MIN_PAYLOAD
                        if (pcnt_q >= P_LAST) begin
                            state_d      = S_IDLE;
                            frame_done_d = 1'b1;
                        end else begin
                            state_d = S_PAD;
                        end
                    end
                end
            end
            S_PAD: begin
                if (m_hs) begin
                    pcnt_d = pcnt_inc;
                    if (m_tlast) begin
                        state_d      = S_IDLE;
                        frame_done_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            sr_q         <= '0;
            hcnt_q       <= 4'd0;
            pcnt_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values computed above.
            state_q      <= state_d;
            sr_q         <= sr_d;
            hcnt_q       <= hcnt_d;
            pcnt_q       <= pcnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_tx_header_ser.sv
// Directed bench for tx_header_ser: expected frame bytes are queued when a frame
// is launched and checked against every valid output beat.

module tb_tx_header_ser;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [111:0] tx_header;
    logic         hdr_valid;
    logic         hdr_ready;
    logic [7:0]   s_tdata;
    logic         s_tvalid;
    logic         s_tlast;
    logic         s_tready;
    logic [7:0]   m_tdata;
    logic         m_tvalid;
    logic         m_tlast;
    logic         m_tready;
    logic         busy;
    logic         frame_done;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } beat_t;

    beat_t sb[$];
    int    checks   = 0;
    int    failures = 0;

    tx_header_ser dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_header  (tx_header),
        .hdr_valid  (hdr_valid),
        .hdr_ready  (hdr_ready),
        .s_tdata    (s_tdata),
        .s_tvalid   (s_tvalid),
        .s_tlast    (s_tlast),
        .s_tready   (s_tready),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tlast    (m_tlast),
        .m_tready   (m_tready),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one frame. toggle applies the 1,0,0,1 m_tready pattern, inject pulses
    // hdr_valid with another header mid-payload, rst_at >= 0 resets at that payload byte.
    task automatic run_frame(input logic [111:0] h, input int n, input bit toggle,
                             input bit inject, input int rst_at);
        logic [7:0] pay[$];
        logic [3:0] pat;
        int         total;
        int         idx;
        int         cyc;
        int         beats;
        bit         aborted;
        pat = 4'b1001;
        for (int i = 0; i < n; i++) pay.push_back(8'(i * 13 + n + 33));
        total = (n < 46) ? 46 : n;
        sb.delete();
        for (int k = 0; k < 14; k++) sb.push_back('{d: h[111-8*k -: 8], l: 1'b0});
        for (int i = 0; i < total; i++)
            sb.push_back('{d: (i < n) ? pay[i] : 8'h00, l: (i == total - 1)});

        @(negedge clk);
        tx_header = h;
        hdr_valid = 1'b1;
        m_tready  = 1'b1;
        #1;
        check("hdr_ready_at_load", 32'(hdr_ready), 1);
        @(negedge clk);
        hdr_valid = 1'b0;
        tx_header = ~h;

        idx = 0;
        cyc = 0;
        beats = 0;
        aborted = 1'b0;
        while (sb.size() > 0 && !aborted) begin
            if (cyc >= 400) begin
                checks++;
                failures++;
                $error("FAIL frame_timeout observed=%0d expected=%0d beats_left", sb.size(), 0);
                break;
            end
            m_tready  = toggle ? pat[3 - (cyc % 4)] : 1'b1;
            s_tvalid  = (idx < n);
            s_tdata   = (idx < n) ? pay[idx] : 8'h00;
            s_tlast   = (idx == n - 1);
            hdr_valid = inject && (idx == 3);
            if (rst_at >= 0 && idx == rst_at) rst_n = 1'b0;
            #1;
            if (!rst_n) begin
                check("rst_m_tvalid", 32'(m_tvalid), 0);
                check("rst_m_tlast", 32'(m_tlast), 0);
                check("rst_hdr_ready", 32'(hdr_ready), 0);
                check("rst_s_tready", 32'(s_tready), 0);
                check("rst_m_tdata", 32'(m_tdata), 0);
                @(negedge clk);
                rst_n     = 1'b1;
                s_tvalid  = 1'b0;
                s_tlast   = 1'b0;
                hdr_valid = 1'b0;
                #1;
                check("post_rst_m_tvalid", 32'(m_tvalid), 0);
                check("post_rst_m_tlast", 32'(m_tlast), 0);
                check("post_rst_busy", 32'(busy), 0);
                check("post_rst_hdr_ready", 32'(hdr_ready), 1);
                sb.delete();
                aborted = 1'b1;
            end else begin
                check("busy_in_frame", 32'(busy), 1);
                check("hdr_ready_in_frame", 32'(hdr_ready), 0);
                check("m_tvalid", 32'(m_tvalid), 1);
                if (m_tvalid) begin
                    check("m_tdata", 32'(m_tdata), 32'(sb[0].d));
                    check("m_tlast", 32'(m_tlast), 32'(sb[0].l));
                end
                if (idx >= n) check("s_tready_in_pad", 32'(s_tready), 0);
                if (m_tvalid && m_tready) begin
                    void'(sb.pop_front());
                    beats++;
                end
                if (s_tvalid && s_tready) idx++;
                @(negedge clk);
            end
            cyc++;
        end

        if (!aborted) begin
            s_tvalid  = 1'b0;
            s_tlast   = 1'b0;
            hdr_valid = 1'b0;
            m_tready  = 1'b1;
            #1;
            check("frame_done_pulse", 32'(frame_done), 1);
            check("hdr_ready_at_done", 32'(hdr_ready), 1);
            check("busy_at_done", 32'(busy), 0);
            check("m_tvalid_idle", 32'(m_tvalid), 0);
            check("beat_count", 32'(beats), 32'(14 + total));
            @(negedge clk);
            #1;
            check("frame_done_one_cycle", 32'(frame_done), 0);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        tx_header = '0;
        hdr_valid = 1'b0;
        s_tdata   = 8'h00;
        s_tvalid  = 1'b0;
        s_tlast   = 1'b0;
        m_tready  = 1'b1;

        @(negedge clk);
        #1;
        check("reset_hdr_ready", 32'(hdr_ready), 0);
        check("reset_m_tvalid", 32'(m_tvalid), 0);
        check("reset_s_tready", 32'(s_tready), 0);
        check("reset_m_tlast", 32'(m_tlast), 0);
        check("reset_m_tdata", 32'(m_tdata), 0);
        check("reset_frame_done", 32'(frame_done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("idle_hdr_ready", 32'(hdr_ready), 1);
        check("idle_busy", 32'(busy), 0);
        check("idle_m_tvalid", 32'(m_tvalid), 0);

        // Long payload, no pad
        run_frame(112'hFFEEDDCCBBAA_112233445566_0800, 60, 1'b0, 1'b0, -1);
        // Short payload, 36 pad bytes
        run_frame(112'h0102030405060708090A0B0C0D0E, 10, 1'b0, 1'b0, -1);
        // Exactly minimum length
        run_frame(112'hA5A5A5A5A5A5_5A5A5A5A5A5A_86DD, 46, 1'b0, 1'b0, -1);
        // Back-pressure pattern through header, payload and pad
        run_frame(112'h001122334455_66778899AABB_CCDD, 10, 1'b1, 1'b0, -1);
        // Header request while busy is ignored
        run_frame(112'h123456789ABC_DEF012345678_9ABC, 20, 1'b0, 1'b1, -1);
        // Reset mid-payload, then a clean frame
        run_frame(112'hCAFEBABEDEAD_BEEF00112233_0806, 30, 1'b0, 1'b0, 5);
        run_frame(112'h0F1E2D3C4B5A_69788796A5B4_C3D2, 30, 1'b0, 1'b0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tx_header_ser.md
Name: tx_header_ser

Overview:
Transmit-side framer for the Ethernet pattern path. It accepts a 112-bit header (type `header` from `defines`: dst MAC[111:64], src MAC[63:16], ethertype[15:0]) through a load handshake and serializes it MSB-byte-first onto an 8-bit AXI-Stream. It then passes the payload stream through unchanged and zero-pads short payloads up to the Ethernet minimum. The output feeds the MAC TX AXI-Stream client interface.

Parameters:
HDR_BYTES, 14, header length in bytes (fixed to match the 112-bit `header` type).
MIN_PAYLOAD, 46, minimum payload bytes per frame; shorter payloads are padded up to this length.
PAD_BYTE, 8'h00, value driven on pad beats.

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
tx_header  in  112 (header)  header to transmit; sampled on load handshake
hdr_valid  in  1  header load request
hdr_ready  out  1  block can accept a header
s_tdata  in  8  payload byte
s_tvalid  in  1  payload byte valid
s_tlast  in  1  last payload byte of frame
s_tready  out  1  payload byte accepted
m_tdata  out  8  frame byte to MAC
m_tvalid  out  1  frame byte valid
m_tlast  out  1  last byte of frame
m_tready  in  1  MAC accepts byte
busy  out  1  frame in progress (state != IDLE)
frame_done  out  1  one-cycle pulse after the final frame byte handshake

Behaviour:
- State and registers.
  - FSM states: IDLE, HDR, PAYLOAD, PAD.
  - 112-bit shift register `sr`.
  - 4-bit header counter `hcnt`.
  - Payload counter `pcnt`, width $clog2(MIN_PAYLOAD+1), saturating at MIN_PAYLOAD.
- Reset (rst_n low at a clock edge):
  - state=IDLE, sr=0, hcnt=0, pcnt=0, frame_done=0.
  - While rst_n is low, all handshake outputs are forced to 0: hdr_ready, s_tready, m_tvalid, m_tlast. m_tdata=0.
  - Reset mid-frame aborts the frame with no m_tlast. After reset, the next frame starts cleanly.
- Handshake rules.
  - A beat transfers when valid and ready are both high at a clock edge.
  - m_tvalid, once asserted, stays high with m_tdata stable until the handshake. This is guaranteed in HDR and PAD; in PAYLOAD it inherits upstream AXI-S compliance.
- IDLE.
  - hdr_ready=1; m_tvalid=0; s_tready=0.
  - On hdr_valid: sr<=tx_header, hcnt<=0, pcnt<=0, go to HDR.
  - The first header byte is visible the next cycle (1-cycle load latency).
- HDR.
  - hdr_ready=0; m_tvalid=1; m_tdata=sr[111:104]; m_tlast=0; s_tready=0.
  - On m handshake: sr<=sr<<8, hcnt++.
  - On the handshake with hcnt==HDR_BYTES-1, go to PAYLOAD.
  - Byte order: dst MAC MSB first, ethertype LSB last. This matches the receiver's shift-in order.
- PAYLOAD (combinational pass-through, zero added latency).
  - m_tdata=s_tdata; m_tvalid=s_tvalid; s_tready=m_tready.
  - m_tlast = s_tlast && (pcnt >= MIN_PAYLOAD-1).
  - On each handshake, pcnt++ (saturating).
  - On a handshake with s_tlast:
    - if pcnt+1 >= MIN_PAYLOAD: go to IDLE and pulse frame_done;
    - otherwise: go to PAD.
  - Payloads longer than MIN_PAYLOAD pass through unmodified; pcnt stays at its saturated value.
- PAD.
  - m_tvalid=1; m_tdata=PAD_BYTE; s_tready=0; m_tlast = (pcnt == MIN_PAYLOAD-1).
  - On handshake: pcnt++.
  - On the handshake with m_tlast: go to IDLE and pulse frame_done.
- frame_done is registered: high for exactly 1 cycle, the cycle after the final handshake. In that same cycle hdr_ready=1.
- hdr_valid asserted while busy is ignored. It is not queued, and tx_header is not re-sampled.
- m_tready low in any state holds state, sr, and counters unchanged.
- Throughput: back-to-back frames have a 1-cycle bubble (IDLE load cycle) between the m_tlast of one frame and the first header byte of the next.

Test Plan:
- Header 112'hFFEEDDCCBBAA_112233445566_0800 with a 60-byte payload, m_tready=1:
  - m_tdata sequence FF,EE,DD,CC,BB,AA,11,22,33,44,55,66,08,00, then the 60 payload bytes;
  - m_tlast on byte 74 only; no pad; frame_done pulses 1 cycle later.
- 10-byte payload (s_tlast on byte 10):
  - 14 header + 10 payload + 36 bytes of 8'h00;
  - m_tlast on the 60th beat; s_tready=0 during PAD.
- Exactly 46-byte payload:
  - m_tlast on the 46th payload byte;
  - FSM goes straight to IDLE and PAD is never entered.
- m_tready toggling 1,0,0,1 during HDR and PAD:
  - m_tdata/m_tvalid hold during stalls;
  - byte order and total count unchanged.
- hdr_valid pulsed with a different header during PAYLOAD:
  - ignored; the current frame completes with the original header bytes;
  - hdr_ready=0 until after frame_done.
- rst_n low for 1 cycle at payload byte 5:
  - next cycle m_tvalid=0, m_tlast=0, busy=0, hdr_ready=1;
  - the following header load produces a correct full frame.
